// File: rtl/serial_parallel.sv
// serial_parallel: I2S receiver for the codec ADC path.
// The inputs bclk, adclrc and adcdat are sampled in the clk_12M domain.
// Each frame carries a left word and a right word, sent MSB first with a
// one-BCLK I2S delay. After a complete left+right pair has been received,
// the pair is presented as a parallel stereo sample with a one-cycle strobe.
//
// Optional feature: define SP_FRAME_CHECK_EN to add the frame_err output
// (short-word detection pulse).
//
// Ports:
//   clk_12M    in   system clock, all logic on rising edge
//   rst        in   asynchronous active-high reset
//   bclk       in   codec bit clock (asynchronous)
//   adclrc     in   word select, 0 = left, 1 = right
//   adcdat     in   serial data, changes on bclk falling edge
//   data_left  out  last complete left word
//   data_right out  last complete right word
//   data_valid out  one-cycle pulse when data_left/data_right update
//   frame_err  out  one-cycle pulse on a short word (SP_FRAME_CHECK_EN only)
module serial_parallel #(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk_12M,
    input  logic                  rst,
    input  logic                  bclk,
    input  logic                  adclrc,
    input  logic                  adcdat,
    output logic [DATA_WIDTH-1:0] data_left,
    output logic [DATA_WIDTH-1:0] data_right,
    output logic                  data_valid
`ifdef SP_FRAME_CHECK_EN
    ,
    output logic                  frame_err
`endif
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StDelay, StShift, StDone} state_e;

    // Synchronizers: bclk gets a third flop for rising-edge detection.
    logic [2:0] bclk_sync_q;
    logic [1:0] lrc_sync_q;
    logic [1:0] dat_sync_q;

    logic rise, lrc, dat, lrc_edge;

    state_e                state_q, state_d;
    logic                  chan_q, chan_d;          // 0 = left, 1 = right
    logic                  lrc_prev_q, lrc_prev_d;
    logic [DATA_WIDTH-2:0] shift_q, shift_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                  left_vld_q, left_vld_d;
    logic [DATA_WIDTH-1:0] data_left_q, data_left_d;
    logic [DATA_WIDTH-1:0] data_right_q, data_right_d;
    logic                  data_valid_q, data_valid_d;
    logic [DATA_WIDTH-1:0] word;
`ifdef SP_FRAME_CHECK_EN
    logic                  frame_err_q, frame_err_d;
`endif

    assign rise     = bclk_sync_q[1] & ~bclk_sync_q[2];
    assign lrc      = lrc_sync_q[1];
    assign dat      = dat_sync_q[1];
    assign lrc_edge = lrc != lrc_prev_q;
    assign word     = {shift_q, dat};

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        lrc_prev_d   = lrc_prev_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        left_hold_d  = left_hold_q;
        left_vld_d   = left_vld_q;
        data_left_d  = data_left_q;
        data_right_d = data_right_q;
        data_valid_d = 1'b0;
`ifdef SP_FRAME_CHECK_EN
        frame_err_d  = 1'b0;
`endif
        // The rise that reveals an LRC edge carries the I2S delay bit and is
        // discarded; DELAY lasts one clk_12M cycle and readies SHIFT so the
        // next rise samples the MSB. Phases of >= 2 cycles mean no rise can
        // fall into that cycle.
        if (state_q == StDelay) begin
            state_d   = StShift;
            bit_cnt_d = '0;
        end else if (rise) begin
            lrc_prev_d = lrc;
            unique case (state_q)
                StIdle: begin
                    // Capture only begins on a left word.
                    if (lrc_edge && !lrc) begin
                        state_d = StDelay;
                        chan_d  = 1'b0;
                    end
                end
                StShift: begin
                    if (lrc_edge) begin
                        // Short word: drop the partial word, restart on new channel.
                        state_d = StDelay;
                        chan_d  = lrc;
                        if (!chan_q) begin
                            left_vld_d = 1'b0;
                        end
`ifdef SP_FRAME_CHECK_EN
                        frame_err_d = 1'b1;
`endif
                    end else begin
                        shift_d   = word[DATA_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                            state_d = StDone;
                            if (!chan_q) begin
                                left_hold_d = word;
                                left_vld_d  = 1'b1;
                            end else if (left_vld_q) begin
                                data_left_d  = left_hold_q;
                                data_right_d = word;
                                data_valid_d = 1'b1;
                                left_vld_d   = 1'b0;  // each pair needs a fresh left word
                            end
                        end
                    end
                end
                StDone: begin
                    if (lrc_edge) begin
                        state_d = StDelay;
                        chan_d  = lrc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_12M or posedge rst) begin
        if (rst) begin
            bclk_sync_q  <= '0;
            lrc_sync_q   <= '0;
            dat_sync_q   <= '0;
            state_q      <= StIdle;
            chan_q       <= 1'b0;
            lrc_prev_q   <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            left_hold_q  <= '0;
            left_vld_q   <= 1'b0;
            data_left_q  <= '0;
            data_right_q <= '0;
            data_valid_q <= 1'b0;
`ifdef SP_FRAME_CHECK_EN
            frame_err_q  <= 1'b0;
`endif
        end else begin
            bclk_sync_q  <= {bclk_sync_q[1:0], bclk};
            lrc_sync_q   <= {lrc_sync_q[0], adclrc};
            dat_sync_q   <= {dat_sync_q[0], adcdat};
            state_q      <= state_d;
            chan_q       <= chan_d;
            lrc_prev_q   <= lrc_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            left_hold_q  <= left_hold_d;
            left_vld_q   <= left_vld_d;
            data_left_q  <= data_left_d;
            data_right_q <= data_right_d;
            data_valid_q <= data_valid_d;
`ifdef SP_FRAME_CHECK_EN
            frame_err_q  <= frame_err_d;
`endif
        end
    end

    assign data_left  = data_left_q;
    assign data_right = data_right_q;
    assign data_valid = data_valid_q;
`ifdef SP_FRAME_CHECK_EN
    assign frame_err  = frame_err_q;
`endif

endmodule

// File: tb/tb_serial_parallel.sv
// Bench for serial_parallel: directed I2S frames and a slot-level model of
// which left/right pairs must appear at the outputs.
module tb_serial_parallel;

    localparam int W = 24;

    logic         clk_12M = 1'b0;
    logic         rst     = 1'b1;
    logic         bclk    = 1'b0;
    logic         adclrc  = 1'b1;
    logic         adcdat  = 1'b0;
    logic [W-1:0] data_left, data_right;
    logic         data_valid;
`ifdef SP_FRAME_CHECK_EN
    logic         frame_err;
    int           n_err   = 0;
    int           exp_err = 0;
`endif

    serial_parallel #(.DATA_WIDTH(W)) dut (
        .clk_12M   (clk_12M),
        .rst       (rst),
        .bclk      (bclk),
        .adclrc    (adclrc),
        .adcdat    (adcdat),
        .data_left (data_left),
        .data_right(data_right),
        .data_valid(data_valid)
`ifdef SP_FRAME_CHECK_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk_12M = ~clk_12M;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_pulse = 0;

    // Model state, at slot granularity.
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   left_val   = '0;
    bit             left_ok    = 0;
    bit             armed      = 0;
    bit             seen_right = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One word-select slot of nbits BCLKs; bit 0 is the I2S delay bit, bits
    // 1..W carry the word MSB first, the rest is filler. If rst_at >= 0,
    // reset is pulsed during that bit.
    task automatic send_slot(input bit lrc, input logic [W-1:0] word, input int nbits,
                             input int half, input int rst_at);
        bit complete;
        bit b;
        complete = (nbits >= W + 1);
        if (lrc) begin
            seen_right = 1;
            if (rst_at < 0 && armed && left_ok && complete) exp_q.push_back({left_val, word});
`ifdef SP_FRAME_CHECK_EN
            if (armed && !complete) exp_err++;
`endif
            left_ok = 0;
        end else begin
            if (seen_right) armed = 1;
            if (armed) begin
                left_ok  = complete;
                left_val = word;
`ifdef SP_FRAME_CHECK_EN
                if (!complete) exp_err++;
`endif
            end
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_async_out", {data_left, data_right, data_valid}, '0);
                exp_q.delete();
                armed      = 0;
                left_ok    = 0;
                seen_right = 0;
            end
            if (i == 0) b = 1'b1;
            else if (i <= W) b = word[W-i];
            else b = 1'b1;
            bclk   = 1'b0;
            adclrc = lrc;
            adcdat = b;
            repeat (half) @(negedge clk_12M);
            bclk = 1'b1;
            if (i == rst_at) begin
                rst = 1'b0;
                if (lrc) seen_right = 1;
            end
            repeat (half) @(negedge clk_12M);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int nbits,
                              input int half);
        send_slot(1'b0, l, nbits, half, -1);
        send_slot(1'b1, r, nbits, half, -1);
    endtask

    // Compare process: every cycle, outputs either hold or show the next
    // expected pair with a single-cycle strobe.
    logic [W-1:0] hold_l = '0;
    logic [W-1:0] hold_r = '0;
    bit           vld_prev = 0;

    always begin
        @(negedge clk_12M);
        #1;
        if (rst) begin
            hold_l   = '0;
            hold_r   = '0;
            vld_prev = 0;
            chk("rst_outputs", {data_left, data_right, data_valid}, '0);
        end else begin
            if (data_valid) begin
                n_pulse++;
                chk("valid_single_cycle", vld_prev, 1'b0);
                chk("valid_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    {hold_l, hold_r} = exp_q.pop_front();
                    chk("pair_left", data_left, hold_l);
                    chk("pair_right", data_right, hold_r);
                end
            end else begin
                chk("hold_left", data_left, hold_l);
                chk("hold_right", data_right, hold_r);
            end
            vld_prev = data_valid;
`ifdef SP_FRAME_CHECK_EN
            if (frame_err) n_err++;
`endif
        end
    end

    initial begin
        @(negedge clk_12M);
        // Start with reset released mid right word: nothing until a full pair.
        send_slot(1'b1, 24'h0F0F0F, 32, 4, 5);
        chk("midframe_no_pulse", n_pulse, 0);

        // Nominal frames, bclk = clk/8, 32-BCLK slots.
        send_frame(24'hA5A5A5, 24'hA12345, 32, 4);
        chk("nominal_left", data_left, 24'hA5A5A5);
        chk("nominal_right", data_right, 24'hA12345);
        chk("nominal_pulses", n_pulse, 1);
        send_frame(24'h123456, 24'hFEDCBA, 32, 4);
        chk("nominal2_left", data_left, 24'h123456);
        chk("nominal2_right", data_right, 24'hFEDCBA);

        // Max rate: bclk = clk/4, 25-BCLK slots, back to back.
        for (int f = 0; f < 3; f++) send_frame(24'h800001, 24'h7FFFFE, 25, 2);
        repeat (10) @(negedge clk_12M);
        chk("maxrate_left", data_left, 24'h800001);
        chk("maxrate_right", data_right, 24'h7FFFFE);
        chk("maxrate_pulses", n_pulse, 5);

        // Reset during bit 10 of a right word.
        send_slot(1'b0, 24'h111111, 32, 4, -1);
        send_slot(1'b1, 24'h222222, 32, 4, 11);
        chk("after_rst_left", data_left, 24'h0);
        chk("after_rst_right", data_right, 24'h0);
        send_frame(24'h333333, 24'h444444, 32, 4);
        chk("post_rst_left", data_left, 24'h333333);
        chk("post_rst_right", data_right, 24'h444444);
        chk("post_rst_pulses", n_pulse, 6);

        // Short right slot of 16 BCLKs, then a normal frame.
        send_slot(1'b0, 24'h555555, 32, 4, -1);
        send_slot(1'b1, 24'h666666, 16, 4, -1);
        send_slot(1'b0, 24'h777777, 32, 4, -1);
        chk("short_held_left", data_left, 24'h333333);
        chk("short_held_right", data_right, 24'h444444);
        chk("short_pulses", n_pulse, 6);
        send_slot(1'b1, 24'h888888, 32, 4, -1);
        repeat (40) @(negedge clk_12M);
        chk("final_left", data_left, 24'h777777);
        chk("final_right", data_right, 24'h888888);
        chk("final_pulses", n_pulse, 7);
        chk("queue_drained", exp_q.size(), 0);
`ifdef SP_FRAME_CHECK_EN
        chk("frame_err_model", n_err, exp_err);
        chk("frame_err_count", n_err, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
